// File: rtl/wb_uart_slave.sv
// Wishbone classic UART slave: TX FIFO feeding a serialiser, 2-flop synchronised
// deserialiser into a one-byte holding register, single-cycle registered terminations.
module wb_uart_slave #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd433
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic [31:0] adr_i,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        uart_tx_o,
  input  logic        uart_rx_i,
  output logic        irq_o
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;

  // Handshake: a request is cyc_i&stb_i while no termination is showing. It is answered
  // next cycle by exactly one of ack_o/err_o for one cycle, so a held strobe terminates
  // every other cycle. Register side effects commit on the request edge.
  logic        req, wr_bad, tx_wr, rx_rd, st_rd, ctrl_wr;
  logic [1:0]  reg_sel;
  logic [31:0] rd_data;

  logic [15:0] div;
  logic        ie_rx, ie_tx;
  logic        rx_valid, overrun, frame_err, tx_overflow;
  logic [7:0]  rx_byte;

  logic [7:0]  fifo_mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_empty, fifo_full, push;
  logic [7:0]  fifo_head;

  uart_state_e tx_state, tx_state_n;
  logic [15:0] tx_cnt, tx_cnt_n, tx_div, tx_div_n;
  logic [2:0]  tx_idx, tx_idx_n;
  logic [7:0]  tx_shift, tx_shift_n;
  logic        tx_pop, tx_busy;

  uart_state_e rx_state, rx_state_n;
  logic [15:0] rx_cnt, rx_cnt_n, rx_div, rx_div_n;
  logic [2:0]  rx_idx, rx_idx_n;
  logic [7:0]  rx_shift, rx_shift_n;
  logic        rx_s1, rx_s2, rx_store, rx_ferr;

  logic unused_bits;
  assign unused_bits = ^{adr_i[31:4], adr_i[1:0], sel_i[3], dat_i[31:18]};

  assign reg_sel = adr_i[3:2];
  assign req     = cyc_i & stb_i & ~ack_o & ~err_o;
  assign wr_bad  = we_i & ((reg_sel == 2'd1) | (reg_sel == 2'd2));
  assign tx_wr   = req & we_i & (reg_sel == 2'd0) & sel_i[0];
  assign rx_rd   = req & ~we_i & (reg_sel == 2'd1);
  assign st_rd   = req & ~we_i & (reg_sel == 2'd2);
  assign ctrl_wr = req & we_i & (reg_sel == 2'd3);

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push       = tx_wr & ~fifo_full;
  assign fifo_head  = fifo_mem[rd_ptr[AW-1:0]];
  assign tx_busy    = (tx_state != S_IDLE);

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      2'd1:    rd_data = {23'b0, rx_valid, rx_byte};
      2'd2:    rd_data = {25'b0, tx_overflow, frame_err, overrun, rx_valid, tx_busy,
                          fifo_empty, fifo_full};
      2'd3:    rd_data = {14'b0, ie_tx, ie_rx, div};
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= dat_i[7:0];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_o <= 1'b0; err_o <= 1'b0; dat_o <= '0; irq_o <= 1'b0;
      wr_ptr <= '0; rd_ptr <= '0;
      div <= DIV_RESET; ie_rx <= 1'b0; ie_tx <= 1'b0;
      rx_valid <= 1'b0; rx_byte <= '0; overrun <= 1'b0; frame_err <= 1'b0; tx_overflow <= 1'b0;
    end else begin
      ack_o <= req & ~wr_bad;
      err_o <= req & wr_bad;
      dat_o <= (req & ~we_i) ? rd_data : '0;
      irq_o <= (ie_rx & rx_valid) | (ie_tx & fifo_empty & ~tx_busy);
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (tx_pop) rd_ptr <= rd_ptr + 1'b1;
      if (ctrl_wr) begin
        if (sel_i[0]) div[7:0]  <= dat_i[7:0];
        if (sel_i[1]) div[15:8] <= dat_i[15:8];
        if (sel_i[2]) begin ie_rx <= dat_i[16]; ie_tx <= dat_i[17]; end
      end
      // A store in the same cycle as an RXDATA read keeps the new byte valid.
      if (rx_store) begin
        rx_byte <= rx_shift; rx_valid <= 1'b1;
      end else if (rx_rd) rx_valid <= 1'b0;
      if (rx_store & rx_valid)    overrun <= 1'b1;
      else if (st_rd)             overrun <= 1'b0;
      if (rx_store & rx_ferr)     frame_err <= 1'b1;
      else if (st_rd)             frame_err <= 1'b0;
      if (tx_wr & fifo_full)      tx_overflow <= 1'b1;
      else if (st_rd)             tx_overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_state <= S_IDLE; tx_cnt <= '0; tx_idx <= '0; tx_shift <= '0; tx_div <= DIV_RESET;
    end else begin
      tx_state <= tx_state_n; tx_cnt <= tx_cnt_n; tx_idx <= tx_idx_n;
      tx_shift <= tx_shift_n; tx_div <= tx_div_n;
    end
  end

  // DIV is captured at each frame start so a mid-frame write cannot stretch a bit.
  always_comb begin
    tx_state_n = tx_state; tx_cnt_n = tx_cnt; tx_idx_n = tx_idx;
    tx_shift_n = tx_shift; tx_div_n = tx_div; tx_pop = 1'b0;
    case (tx_state)
      S_IDLE: if (!fifo_empty) begin
        tx_pop = 1'b1; tx_shift_n = fifo_head; tx_div_n = div; tx_cnt_n = '0; tx_state_n = S_START;
      end
      S_START: if (tx_cnt == tx_div) begin
        tx_cnt_n = '0; tx_idx_n = '0; tx_state_n = S_DATA;
      end else tx_cnt_n = tx_cnt + 16'd1;
      S_DATA: if (tx_cnt == tx_div) begin
        tx_cnt_n = '0; tx_shift_n = {1'b0, tx_shift[7:1]}; tx_idx_n = tx_idx + 3'd1;
        if (tx_idx == 3'd7) tx_state_n = S_STOP;
      end else tx_cnt_n = tx_cnt + 16'd1;
      S_STOP: if (tx_cnt == tx_div) begin
        tx_cnt_n = '0;
        if (!fifo_empty) begin
          tx_pop = 1'b1; tx_shift_n = fifo_head; tx_div_n = div; tx_state_n = S_START;
        end else tx_state_n = S_IDLE;
      end else tx_cnt_n = tx_cnt + 16'd1;
      default: tx_state_n = S_IDLE;
    endcase
  end

  assign uart_tx_o = (tx_state == S_START) ? 1'b0 :
                     (tx_state == S_DATA)  ? tx_shift[0] : 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_s1 <= 1'b1; rx_s2 <= 1'b1;
      rx_state <= S_IDLE; rx_cnt <= '0; rx_idx <= '0; rx_shift <= '0; rx_div <= DIV_RESET;
    end else begin
      rx_s1 <= uart_rx_i; rx_s2 <= rx_s1;
      rx_state <= rx_state_n; rx_cnt <= rx_cnt_n; rx_idx <= rx_idx_n;
      rx_shift <= rx_shift_n; rx_div <= rx_div_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state; rx_cnt_n = rx_cnt; rx_idx_n = rx_idx;
    rx_shift_n = rx_shift; rx_div_n = rx_div; rx_store = 1'b0; rx_ferr = 1'b0;
    case (rx_state)
      S_IDLE: if (!rx_s2) begin
        rx_cnt_n = '0; rx_div_n = div; rx_state_n = S_START;
      end
      S_START: if (rx_cnt == (rx_div >> 1)) begin
        rx_cnt_n = '0; rx_idx_n = '0;
        rx_state_n = rx_s2 ? S_IDLE : S_DATA;
      end else rx_cnt_n = rx_cnt + 16'd1;
      S_DATA: if (rx_cnt == rx_div) begin
        rx_cnt_n = '0; rx_shift_n = {rx_s2, rx_shift[7:1]}; rx_idx_n = rx_idx + 3'd1;
        if (rx_idx == 3'd7) rx_state_n = S_STOP;
      end else rx_cnt_n = rx_cnt + 16'd1;
      S_STOP: if (rx_cnt == rx_div) begin
        rx_store = 1'b1; rx_ferr = ~rx_s2; rx_cnt_n = '0; rx_state_n = S_IDLE;
      end else rx_cnt_n = rx_cnt + 16'd1;
      default: rx_state_n = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_wb_uart_slave.sv
// Bench for wb_uart_slave: bus and serial scoreboards fed by a register/line-level model.
module tb_wb_uart_slave;
  localparam int FIFO_DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_i, cyc_i, stb_i, we_i, uart_rx_i;
  logic [31:0] adr_i, dat_i, dat_o;
  logic [3:0]  sel_i;
  logic        ack_o, err_o, uart_tx_o, irq_o;

  wb_uart_slave #(.FIFO_DEPTH(FIFO_DEPTH), .DIV_RESET(16'd433)) dut (
    .clk_i(clk), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i), .adr_i(adr_i), .we_i(we_i),
    .sel_i(sel_i), .dat_i(dat_i), .dat_o(dat_o), .ack_o(ack_o), .err_o(err_o),
    .uart_tx_o(uart_tx_o), .uart_rx_i(uart_rx_i), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Bus expectation: {is_err, check_data, data}. TX expectation: bytes in wire order.
  logic [33:0] exp_q[$];
  logic [7:0]  tx_exp_q[$];
  int          tx_bit_len;

  logic [15:0] m_div;
  logic        m_ie_rx, m_ie_tx, m_rx_valid, m_overrun, m_ferr, m_txovf;
  logic [7:0]  m_rx_byte;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_div = 16'd433; m_ie_rx = 0; m_ie_tx = 0; m_rx_valid = 0; m_overrun = 0;
    m_ferr = 0; m_txovf = 0; m_rx_byte = 0; tx_bit_len = 434;
    tx_exp_q.delete();
  endtask

  // Bytes not yet finished on the wire; one of them is in the shift register while busy.
  function automatic int m_in_fifo();
    return (tx_exp_q.size() > 0) ? tx_exp_q.size() - 1 : 0;
  endfunction

  function automatic logic [31:0] m_status();
    logic busy;
    busy = (tx_exp_q.size() > 0);
    return {25'b0, m_txovf, m_ferr, m_overrun, m_rx_valid, busy,
            m_in_fifo() == 0, m_in_fifo() == FIFO_DEPTH};
  endfunction

  function automatic logic m_irq();
    return (m_ie_rx & m_rx_valid) | (m_ie_tx & (tx_exp_q.size() == 0));
  endfunction

  // Called at posedge+1; returns at posedge+1 after the termination cycle.
  task automatic bus(input logic we, input logic [1:0] a, input logic [3:0] sel,
                     input logic [31:0] d, input logic [33:0] e);
    exp_q.push_back(e);
    cyc_i = 1; stb_i = 1; we_i = we; adr_i = {28'h0, a, 2'b00}; sel_i = sel; dat_i = d;
    @(posedge clk); @(posedge clk); #1;
    cyc_i = 0; stb_i = 0; we_i = 0;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [3:0] sel, input logic [31:0] d);
    logic [33:0] e;
    e = {2'b00, 32'h0};
    case (a)
      2'd0: if (sel[0]) begin
        if (m_in_fifo() == FIFO_DEPTH) m_txovf = 1;
        else tx_exp_q.push_back(d[7:0]);
      end
      2'd1, 2'd2: e = {2'b10, 32'h0};
      default: begin
        if (sel[0]) m_div[7:0]  = d[7:0];
        if (sel[1]) m_div[15:8] = d[15:8];
        if (sel[2]) begin m_ie_rx = d[16]; m_ie_tx = d[17]; end
        tx_bit_len = int'(m_div) + 1;
      end
    endcase
    bus(1'b1, a, sel, d, e);
  endtask

  task automatic rd_reg(input logic [1:0] a);
    logic [31:0] e;
    case (a)
      2'd0: e = 32'h0;
      2'd1: begin e = {23'b0, m_rx_valid, m_rx_byte}; m_rx_valid = 0; end
      2'd2: begin e = m_status(); m_overrun = 0; m_ferr = 0; m_txovf = 0; end
      default: e = {14'b0, m_ie_tx, m_ie_rx, m_div};
    endcase
    bus(1'b0, a, 4'hf, 32'h0, {2'b01, e});
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx_i = bits[i];
      repeat (int'(m_div) + 1) @(posedge clk);
      #1;
    end
    uart_rx_i = 1;
    repeat (4) @(posedge clk);
    #1;
    if (m_rx_valid) m_overrun = 1;
    m_rx_byte = b; m_rx_valid = 1;
    if (!stop) m_ferr = 1;
  endtask

  task automatic wait_tx_idle(input int budget);
    int n;
    n = 0;
    while (tx_exp_q.size() != 0 && n < budget) begin @(posedge clk); n++; end
    repeat (4) @(posedge clk);
    #1;
    check("tx_drain", tx_exp_q.size(), 0);
  endtask

  // Bus monitor: every termination consumes one expectation.
  always @(negedge clk) begin
    if (ack_o || err_o) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL bus_unexpected: got ack=%b err=%b expected no termination", ack_o, err_o);
      end else begin
        logic [33:0] e;
        e = exp_q.pop_front();
        check("bus_term", {30'b0, ack_o, err_o}, e[33] ? 32'd1 : 32'd2);
        if (e[32]) check("bus_rdata", dat_o, e[31:0]);
      end
    end
  end

  // Serial monitor: decodes each frame, checks every bit holds for its whole period.
  initial begin : tx_mon
    logic [7:0] got, e;
    logic ok, abort, lvl, pend;
    int bl;
    forever begin
      @(negedge clk);
      while (uart_tx_o === 1'b0 && !rst_i) begin
        bl = tx_bit_len; ok = 1; abort = 0; got = 0; lvl = 0;
        for (int b = 0; b < 10; b++) begin
          for (int c = 0; c < bl; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (rst_i) abort = 1;
            if (c == 0) lvl = uart_tx_o;
            else if (uart_tx_o !== lvl) ok = 0;
            if (b >= 1 && b <= 8 && c == 0) got[b-1] = lvl;
          end
        end
        if (!abort) begin
          if (tx_exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL tx_unexpected: got frame %h expected none", got);
          end else begin
            e = tx_exp_q.pop_front();
            check("tx_frame", {22'b0, ok, lvl, got}, {22'b0, 1'b1, 1'b1, e});
          end
          pend = (tx_exp_q.size() != 0);
          @(negedge clk);
          if (pend && !rst_i) check("tx_gap", {31'b0, uart_tx_o}, 32'd0);
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got no finish expected finish, bad=%0d", bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [3:0] pat;
    logic [7:0] b;
    rst_i = 1; cyc_i = 0; stb_i = 0; we_i = 0; adr_i = 0; sel_i = 0; dat_i = 0; uart_rx_i = 1;
    m_reset();
    repeat (2) @(posedge clk);
    #1 rst_i = 0;
    @(negedge clk);
    check("rst_tx", {31'b0, uart_tx_o}, 32'd1);
    check("rst_ack", {31'b0, ack_o}, 32'd0);
    check("rst_err", {31'b0, err_o}, 32'd0);
    check("rst_irq", {31'b0, irq_o}, 32'd0);
    check("rst_dat", dat_o, 32'd0);
    @(posedge clk); #1;
    rd_reg(2'd3);
    rd_reg(2'd2);

    // Bus errors, TXDATA read, and termination cadence under a held strobe.
    wr_reg(2'd1, 4'hf, 32'h55);
    wr_reg(2'd2, 4'hf, 32'h7f);
    rd_reg(2'd2);
    rd_reg(2'd0);
    wr_reg(2'd0, 4'he, 32'h77);
    rd_reg(2'd2);
    exp_q.push_back({2'b01, 14'b0, m_ie_tx, m_ie_rx, m_div});
    exp_q.push_back({2'b01, 14'b0, m_ie_tx, m_ie_rx, m_div});
    cyc_i = 1; stb_i = 1; we_i = 0; adr_i = 32'hc; sel_i = 4'hf;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); pat[i] = ack_o;
      @(posedge clk);
    end
    #1 cyc_i = 0; stb_i = 0;
    check("held_ack_pattern", {28'b0, pat}, 32'hA);

    // Single frame.
    wr_reg(2'd3, 4'hf, 32'h3);
    wr_reg(2'd0, 4'h1, 32'hA5);
    repeat (10) @(posedge clk);
    #1 rd_reg(2'd2);
    wait_tx_idle(200);
    rd_reg(2'd2);

    // FIFO overflow and contiguous frames.
    for (int i = 0; i < 10; i++) wr_reg(2'd0, 4'h1, i);
    rd_reg(2'd2);
    rd_reg(2'd2);
    wait_tx_idle(1000);
    rd_reg(2'd2);

    // Random frames, including the one-cycle bit period.
    for (int r = 0; r < 4; r++) begin
      wr_reg(2'd3, 4'h3, (r == 0) ? 32'h0 : $urandom_range(0, 5));
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) wr_reg(2'd0, 4'h1, $urandom_range(0, 255));
      wait_tx_idle(400);
    end

    // Receive path: overrun, random bytes, framing error.
    wr_reg(2'd3, 4'h3, 32'h3);
    rx_frame(8'h3C, 1'b1);
    rx_frame(8'h81, 1'b1);
    rd_reg(2'd1);
    rd_reg(2'd2);
    for (int r = 0; r < 4; r++) begin
      wr_reg(2'd3, 4'h3, $urandom_range(1, 6));
      rx_frame(8'($urandom_range(0, 255)), 1'b1);
      rd_reg(2'd1);
    end
    rx_frame(8'($urandom_range(0, 255)), 1'b0);
    repeat (20) @(posedge clk);
    #1 rd_reg(2'd2);
    rd_reg(2'd1);

    // Interrupts.
    wr_reg(2'd3, 4'h7, 32'h0001_0003);
    @(negedge clk); check("irq_idle", {31'b0, irq_o}, {31'b0, m_irq()});
    @(posedge clk); #1;
    b = 8'($urandom_range(0, 255));
    rx_frame(b, 1'b1);
    @(negedge clk); check("irq_rx", {31'b0, irq_o}, {31'b0, m_irq()});
    @(posedge clk); #1;
    rd_reg(2'd1);
    @(negedge clk); check("irq_rx_clr", {31'b0, irq_o}, {31'b0, m_irq()});
    @(posedge clk); #1;
    wr_reg(2'd3, 4'h4, 32'h0002_0000);
    @(negedge clk); check("irq_tx", {31'b0, irq_o}, {31'b0, m_irq()});
    @(posedge clk); #1;
    wr_reg(2'd3, 4'h4, 32'h0);

    // Reset in the middle of a frame with a byte still queued.
    wr_reg(2'd3, 4'h7, 32'h3);
    wr_reg(2'd0, 4'h1, 32'h5A);
    wr_reg(2'd0, 4'h1, 32'hC3);
    repeat (12) @(posedge clk);
    #1 rst_i = 1;
    @(posedge clk);
    #1 rst_i = 0;
    m_reset();
    @(negedge clk); check("midrst_tx", {31'b0, uart_tx_o}, 32'd1);
    repeat (8) @(posedge clk);
    @(negedge clk); check("midrst_tx_hold", {31'b0, uart_tx_o}, 32'd1);
    @(posedge clk); #1;
    rd_reg(2'd2);
    rd_reg(2'd3);

    repeat (5) @(posedge clk);
    check("bus_drain", exp_q.size(), 0);
    check("tx_left", tx_exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
